// File: rtl/control_sequencer.sv
// Microprogram sequencer: next-state select, decode entry, microbranches,
// a small return stack for microsubroutines and an MFA wait stall.
module control_sequencer #(
  parameter int unsigned       ADDR_W      = 7,
  parameter int unsigned       STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_STATE = '0,
  parameter logic [ADDR_W-1:0] FETCH_STATE = ADDR_W'(1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] encOut,
  input  logic              instCond,
  input  logic [2:0]        ns,
  input  logic [ADDR_W-1:0] crAddr,
  input  logic              cond,
  input  logic              mfa,
  output logic [ADDR_W-1:0] state,
  output logic              waiting,
  output logic              stackErr
);

  localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IDX_W =
    (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  typedef enum logic [2:0] {
    NS_INC    = 3'b000,
    NS_JUMP   = 3'b001,
    NS_DECODE = 3'b010,
    NS_BRT    = 3'b011,
    NS_BRF    = 3'b100,
    NS_CALL   = 3'b101,
    NS_RET    = 3'b110,
    NS_WAIT   = 3'b111
  } ns_e;

  ns_e               op;
  logic [ADDR_W-1:0] state_q, state_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic              stack_err_q, stack_err_d;
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
  logic [ADDR_W-1:0] inc;
  logic [IDX_W-1:0]  push_idx;
  logic [IDX_W-1:0]  pop_idx;
  logic              push;

  assign op       = ns_e'(ns);
  assign inc      = state_q + ADDR_W'(1);
  assign push_idx = IDX_W'(sp_q);
  assign pop_idx  = IDX_W'(sp_q - SP_W'(1));

  always_comb begin
    state_d     = state_q;
    sp_d        = sp_q;
    stack_err_d = stack_err_q;
    push        = 1'b0;
    unique case (op)
      NS_INC:    state_d = inc;
      NS_JUMP:   state_d = crAddr;
      NS_DECODE: state_d = instCond ? encOut : FETCH_STATE;
      NS_BRT:    state_d = cond ? crAddr : inc;
      NS_BRF:    state_d = cond ? inc : crAddr;
      NS_CALL: begin
        // A full stack still takes the jump; only the push is lost.
        state_d = crAddr;
        if (sp_q == SP_FULL) begin
          stack_err_d = 1'b1;
        end else begin
          push = 1'b1;
          sp_d = sp_q + SP_W'(1);
        end
      end
      NS_RET: begin
        if (sp_q == '0) begin
          state_d     = FETCH_STATE;
          stack_err_d = 1'b1;
        end else begin
          state_d = stack_q[pop_idx];
          sp_d    = sp_q - SP_W'(1);
        end
      end
      NS_WAIT:   state_d = mfa ? inc : state_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RESET_STATE;
      sp_q        <= '0;
      stack_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sp_q        <= sp_d;
      stack_err_q <= stack_err_d;
    end
  end

  // Stack contents are don't-care after reset; sp alone defines validity.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      stack_q[push_idx] <= inc;
    end
  end

  assign state    = state_q;
  assign stackErr = stack_err_q;
  assign waiting  = (op == NS_WAIT) && !mfa;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: directed plan sequences then
// random ns traffic, checked against a queue-based reference model.
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] encOut;
  logic       instCond;
  logic [2:0] ns;
  logic [6:0] crAddr;
  logic       cond;
  logic       mfa;
  logic [6:0] state;
  logic       waiting;
  logic       stackErr;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int st;
    bit err;
    bit wt;
  } exp_t;

  exp_t sb[$];

  int m_state = 0;
  bit m_err   = 1'b0;
  int m_stk[$];

  always #5 clk = ~clk;

  control_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .encOut   (encOut),
    .instCond (instCond),
    .ns       (ns),
    .crAddr   (crAddr),
    .cond     (cond),
    .mfa      (mfa),
    .state    (state),
    .waiting  (waiting),
    .stackErr (stackErr)
  );

  // Reference: state as an integer, return stack as a bounded queue.
  task automatic model_step(input bit r, input int op, input int enc,
                            input bit ic, input int cr, input bit c,
                            input bit m);
    int nxt;
    nxt = (m_state + 1) % 128;
    if (r) begin
      m_state = 0;
      m_err   = 1'b0;
      m_stk.delete();
    end else begin
      case (op)
        0: m_state = nxt;
        1: m_state = cr;
        2: m_state = ic ? enc : 1;
        3: m_state = c ? cr : nxt;
        4: m_state = c ? nxt : cr;
        5: begin
          if (m_stk.size() < 4) m_stk.push_back(nxt);
          else m_err = 1'b1;
          m_state = cr;
        end
        6: begin
          if (m_stk.size() == 0) begin
            m_state = 1;
            m_err   = 1'b1;
          end else begin
            m_state = m_stk.pop_back();
          end
        end
        default: if (m) m_state = nxt;
      endcase
    end
  endtask

  task automatic apply(input bit r, input int op, input int enc = 0,
                       input bit ic = 0, input int cr = 0,
                       input bit c = 0, input bit m = 0);
    exp_t e;
    @(negedge clk);
    reset    = r;
    ns       = 3'(op);
    encOut   = 7'(enc);
    instCond = ic;
    crAddr   = 7'(cr);
    cond     = c;
    mfa      = m;
    e.wt = (op == 7) && !m;
    model_step(r, op, enc, ic, cr, c, m);
    e.st  = m_state;
    e.err = m_err;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (int'(state) != e.st) begin
          failures++;
          $display("FAIL state: got %0d want %0d", state, e.st);
        end
        checks++;
        if (stackErr !== e.err) begin
          failures++;
          $display("FAIL stackErr: got %b want %b", stackErr, e.err);
        end
        checks++;
        if (waiting !== e.wt) begin
          failures++;
          $display("FAIL waiting: got %b want %b", waiting, e.wt);
        end
      end
    end
  end

  initial begin : driver
    int n;
    reset = 1'b1; ns = 3'd0; encOut = '0; instCond = 1'b0;
    crAddr = '0; cond = 1'b0; mfa = 1'b0;

    apply(1, 0);
    repeat (3) apply(0, 0);
    apply(0, 1, .cr(127));
    apply(0, 0);

    apply(0, 2, .enc(10), .ic(1));
    apply(0, 2, .enc(10), .ic(0));

    apply(0, 1, .cr(5)); apply(0, 3, .cr(40), .c(1));
    apply(0, 1, .cr(5)); apply(0, 3, .cr(40), .c(0));
    apply(0, 1, .cr(5)); apply(0, 4, .cr(40), .c(0));
    apply(0, 1, .cr(5)); apply(0, 4, .cr(40), .c(1));

    apply(0, 1, .cr(20));
    repeat (3) apply(0, 7, .m(0));
    apply(0, 7, .m(1));
    apply(0, 1, .cr(20));
    apply(0, 7, .m(0));
    apply(1, 7, .m(0));

    apply(0, 1, .cr(8));
    apply(0, 5, .cr(30));
    apply(0, 5, .cr(50));
    apply(0, 5, .cr(70));
    apply(0, 0);
    repeat (3) apply(0, 6);

    apply(0, 5, .cr(11)); apply(0, 5, .cr(22));
    apply(0, 5, .cr(33)); apply(0, 5, .cr(44));
    apply(0, 5, .cr(99));
    repeat (4) apply(0, 6);
    apply(0, 6);
    repeat (3) apply(0, 0);
    apply(1, 0);
    apply(0, 0);

    for (int i = 0; i < 800; i++) begin
      n = $urandom_range(0, 63);
      apply(n == 0, $urandom_range(0, 7), $urandom_range(0, 127),
            1'($urandom), $urandom_range(0, 127), 1'($urandom),
            $urandom_range(0, 2) != 0);
    end

    n = 0;
    while (sb.size() > 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    #2;
    if (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d left want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
